// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: payout state encoding, coin values and
// the coin selection rule used by both the controller and the payout unit.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIME   = 2'd1,
        NICKEL = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DIME_VALUE   = 10;
    localparam int NICKEL_VALUE = 5;

    // Dimes first; nickels only if a dime cannot be paid; otherwise finish.
    function automatic state_t select_coin(input logic dime_ok, input logic nickel_ok);
        if (dime_ok) begin
            return DIME;
        end else if (nickel_ok) begin
            return NICKEL;
        end else begin
            return DONE;
        end
    endfunction

endpackage

// File: rtl/stock_counter.sv
// Hopper inventory counter: saturating restock, decrement per ejected coin,
// simultaneous restock and eject cancel out.
module stock_counter #(
    parameter int STOCK_W = 8,
    parameter int INIT    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [STOCK_W-1:0] count
);

    localparam logic [STOCK_W-1:0] MAX_COUNT  = '1;
    localparam logic [STOCK_W-1:0] INIT_COUNT = STOCK_W'(INIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= INIT_COUNT;
        end else if (inc && !dec) begin
            if (count != MAX_COUNT) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_payout.sv
// Coin payout unit: accepts a change amount and pays it out one coin at a time,
// dimes preferred, reporting any amount the hoppers could not cover.
module coin_payout
    import vend_pkg::*;
#(
    parameter int N            = 6,
    parameter int STOCK_W      = 8,
    parameter int INIT_DIMES   = 20,
    parameter int INIT_NICKELS = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [N-1:0]       req_amount,
    output logic               req_ready,
    output logic               dime_req,
    output logic               nickel_req,
    input  logic               coin_ack,
    input  logic               restock_dime,
    input  logic               restock_nickel,
    output logic [STOCK_W-1:0] dime_stock,
    output logic [STOCK_W-1:0] nickel_stock,
    output logic               done,
    output logic               short,
    output logic [N-1:0]       remainder
);

    localparam logic [N-1:0] DIME_AMT   = N'(DIME_VALUE);
    localparam logic [N-1:0] NICKEL_AMT = N'(NICKEL_VALUE);

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] remaining_q;
    logic [N-1:0] remaining_d;
    logic [N-1:0] sel_value;
    logic         do_select;
    logic         enter_done;
    logic         short_q;
    logic [N-1:0] remainder_q;
    logic         dime_ack;
    logic         nickel_ack;
    logic         dime_avail;
    logic         nickel_avail;

    assign dime_ack   = (state_q == DIME) && coin_ack;
    assign nickel_ack = (state_q == NICKEL) && coin_ack;

    stock_counter #(
        .STOCK_W (STOCK_W),
        .INIT    (INIT_DIMES)
    ) u_dime_stock (
        .clk   (clk),
        .reset (reset),
        .inc   (restock_dime),
        .dec   (dime_ack),
        .count (dime_stock)
    );

    stock_counter #(
        .STOCK_W (STOCK_W),
        .INIT    (INIT_NICKELS)
    ) u_nickel_stock (
        .clk   (clk),
        .reset (reset),
        .inc   (restock_nickel),
        .dec   (nickel_ack),
        .count (nickel_stock)
    );

    // After an acked coin, selection must see the stock as it will be next cycle.
    assign dime_avail   = dime_ack   ? ((dime_stock > STOCK_W'(1)) || restock_dime)
                                     : (dime_stock != '0);
    assign nickel_avail = nickel_ack ? ((nickel_stock > STOCK_W'(1)) || restock_nickel)
                                     : (nickel_stock != '0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sel_value   = '0;
        do_select   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    remaining_d = req_amount;
                    sel_value   = req_amount;
                    do_select   = 1'b1;
                end
            end
            DIME: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - DIME_AMT;
                    sel_value   = remaining_d;
                    do_select   = 1'b1;
                end
            end
            NICKEL: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - NICKEL_AMT;
                    sel_value   = remaining_d;
                    do_select   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_select) begin
            state_d = select_coin((sel_value >= DIME_AMT) && dime_avail,
                                  (sel_value >= NICKEL_AMT) && nickel_avail);
        end
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            short_q     <= 1'b0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            if (enter_done) begin
                remainder_q <= remaining_d;
                short_q     <= (remaining_d >= NICKEL_AMT);
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign dime_req   = (state_q == DIME);
    assign nickel_req = (state_q == NICKEL);
    assign done       = (state_q == DONE);
    assign short      = short_q;
    assign remainder  = remainder_q;

endmodule

// File: tb/tb_coin_payout.sv
// Directed bench for coin_payout: a table of payouts with hand-computed coin
// counts and stocks, plus sequences for delayed acks, restock-on-ack and reset.
module tb_coin_payout;

    localparam int N       = 6;
    localparam int STOCK_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic [N-1:0]       req_amount;
    logic               req_ready;
    logic               dime_req;
    logic               nickel_req;
    logic               coin_ack;
    logic               restock_dime;
    logic               restock_nickel;
    logic [STOCK_W-1:0] dime_stock;
    logic [STOCK_W-1:0] nickel_stock;
    logic               done;
    logic               short;
    logic [N-1:0]       remainder;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int amount;
        int restock_d;
        int restock_n;
        int exp_dimes;
        int exp_nickels;
        int exp_short;
        int exp_rem;
        int exp_dstock;
        int exp_nstock;
    } vec_t;

    vec_t vecs[11];

    coin_payout #(
        .N            (N),
        .STOCK_W      (STOCK_W),
        .INIT_DIMES   (20),
        .INIT_NICKELS (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_amount     (req_amount),
        .req_ready      (req_ready),
        .dime_req       (dime_req),
        .nickel_req     (nickel_req),
        .coin_ack       (coin_ack),
        .restock_dime   (restock_dime),
        .restock_nickel (restock_nickel),
        .dime_stock     (dime_stock),
        .nickel_stock   (nickel_stock),
        .done           (done),
        .short          (short),
        .remainder      (remainder)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_restock(input int nd, input int nn);
        int total;
        total = (nd > nn) ? nd : nn;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            restock_dime   = (i < nd);
            restock_nickel = (i < nn);
        end
        @(negedge clk);
        restock_dime   = 1'b0;
        restock_nickel = 1'b0;
    endtask

    // Issue one request and act as the hopper until done, counting coins.
    task automatic run_payout(input int amount, input int ack_delay, input bit restock_on_ack,
                              output int nd, output int nn, output int sh, output int rem,
                              output int req_cycles);
        int waited;
        bit finished;
        nd = 0; nn = 0; sh = -1; rem = -1; req_cycles = 0;
        waited = 0;
        finished = 1'b0;
        @(negedge clk);
        check_output("ready_before_req", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_amount = N'(amount);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("first_response", int'(dime_req | nickel_req | done), 1);
        for (int c = 0; c < 400 && !finished; c++) begin
            coin_ack     = 1'b0;
            restock_dime = 1'b0;
            if (done) begin
                sh = int'(short);
                rem = int'(remainder);
                finished = 1'b1;
            end else if (dime_req || nickel_req) begin
                req_cycles++;
                if (waited >= ack_delay) begin
                    coin_ack = 1'b1;
                    waited = 0;
                    if (dime_req) begin
                        nd++;
                        restock_dime = restock_on_ack;
                    end else begin
                        nn++;
                    end
                end else begin
                    waited++;
                end
            end
            if (!finished) @(negedge clk);
        end
        coin_ack     = 1'b0;
        restock_dime = 1'b0;
        checks++;
        if (!finished) begin
            fails++;
            $display("[TB] FAIL payout_timeout: amount %0d never reached done", amount);
        end else begin
            @(negedge clk);
            check_output("ready_after_done", int'(req_ready), 1);
            check_output("done_one_cycle", int'(done), 0);
        end
    endtask

    task automatic apply_stimulus(input int idx);
        int nd, nn, sh, rem, rc;
        do_restock(vecs[idx].restock_d, vecs[idx].restock_n);
        run_payout(vecs[idx].amount, 0, 1'b0, nd, nn, sh, rem, rc);
        $display("[TB] vector %0d amount %0d: dimes %0d nickels %0d short %0d rem %0d",
                 idx, vecs[idx].amount, nd, nn, sh, rem);
        check_output("dimes_paid", nd, vecs[idx].exp_dimes);
        check_output("nickels_paid", nn, vecs[idx].exp_nickels);
        check_output("short", sh, vecs[idx].exp_short);
        check_output("remainder", rem, vecs[idx].exp_rem);
        check_output("dime_stock", int'(dime_stock), vecs[idx].exp_dstock);
        check_output("nickel_stock", int'(nickel_stock), vecs[idx].exp_nstock);
    endtask

    initial begin
        int nd, nn, sh, rem, rc;

        //            amt rd rn  d  n sh rem  ds  ns
        vecs[0]  = '{35, 0, 0, 3, 1, 0,  0, 17, 19};
        vecs[1]  = '{60, 0, 0, 6, 0, 0,  0, 11, 19};
        vecs[2]  = '{60, 0, 0, 6, 0, 0,  0,  5, 19};
        vecs[3]  = '{40, 0, 0, 4, 0, 0,  0,  1, 19};
        vecs[4]  = '{35, 0, 0, 1, 5, 0,  0,  0, 14};
        vecs[5]  = '{60, 0, 0, 0,12, 0,  0,  0,  2};
        vecs[6]  = '{30, 0, 0, 0, 2, 1, 20,  0,  0};
        vecs[7]  = '{33, 3, 2, 3, 0, 0,  3,  0,  2};
        vecs[8]  = '{ 0, 0, 0, 0, 0, 0,  0,  0,  2};
        vecs[9]  = '{ 7, 0, 0, 0, 1, 0,  2,  0,  1};
        vecs[10] = '{63, 2, 0, 2, 1, 1, 38,  0,  0};

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_amount     = '0;
        coin_ack       = 1'b0;
        restock_dime   = 1'b0;
        restock_nickel = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_dime_stock", int'(dime_stock), 20);
        check_output("reset_nickel_stock", int'(nickel_stock), 20);
        check_output("reset_done", int'(done), 0);
        check_output("reset_dime_req", int'(dime_req), 0);
        reset = 1'b0;
        @(negedge clk);
        check_output("ready_after_reset", int'(req_ready), 1);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(i);
        end

        // Hopper slow by four cycles: request held five cycles, one coin counted.
        do_restock(2, 0);
        run_payout(10, 4, 1'b0, nd, nn, sh, rem, rc);
        check_output("delay_req_cycles", rc, 5);
        check_output("delay_dimes", nd, 1);
        check_output("delay_dime_stock", int'(dime_stock), 1);
        check_output("delay_remainder", rem, 0);

        // Restock on the same edge as a dime ack leaves the count unchanged.
        run_payout(10, 0, 1'b1, nd, nn, sh, rem, rc);
        check_output("restock_on_ack_stock", int'(dime_stock), 1);
        check_output("restock_on_ack_dimes", nd, 1);

        // Reset in the middle of a 40-cent payout, right after the second ack.
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = N'(40);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("midreset_dime_req", int'(dime_req), 1);
        do_restock(19, 0);
        check_output("midreset_stock_before", int'(dime_stock), 20);
        coin_ack = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        coin_ack = 1'b0;
        reset    = 1'b1;
        #1;
        check_output("midreset_dime_req_cleared", int'(dime_req), 0);
        check_output("midreset_nickel_req", int'(nickel_req), 0);
        check_output("midreset_done", int'(done), 0);
        check_output("midreset_short", int'(short), 0);
        check_output("midreset_remainder", int'(remainder), 0);
        check_output("midreset_dime_stock", int'(dime_stock), 20);
        check_output("midreset_nickel_stock", int'(nickel_stock), 20);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("postreset_ready", int'(req_ready), 1);

        run_payout(25, 0, 1'b0, nd, nn, sh, rem, rc);
        check_output("postreset_dimes", nd, 2);
        check_output("postreset_nickels", nn, 1);
        check_output("postreset_short", sh, 0);
        check_output("postreset_remainder", rem, 0);
        check_output("postreset_dime_stock", int'(dime_stock), 18);
        check_output("postreset_nickel_stock", int'(nickel_stock), 19);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/coin_payout.md
# coin_payout

Coin payout unit: the dispensing end of the vending machine's coin path. It accepts a change amount from the vending controller over a valid/ready handshake. It pays that amount out one coin at a time to a dime hopper and a nickel hopper, preferring dimes. It tracks hopper inventory and reports any amount it could not pay.

## Interface
Parameters:
- N, 6, width of amount and remainder (cents)
- STOCK_W, 8, width of each hopper stock counter
- INIT_DIMES, 20, dime stock loaded at reset
- INIT_NICKELS, 20, nickel stock loaded at reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  change request present
- req_amount  in  N  change to pay, in cents
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid && req_ready
- dime_req  out  1  dime hopper: eject one dime
- nickel_req  out  1  nickel hopper: eject one nickel
- coin_ack  in  1  hopper confirms one coin ejected this cycle
- restock_dime  in  1  add one dime to stock
- restock_nickel  in  1  add one nickel to stock
- dime_stock  out  STOCK_W  current dime inventory
- nickel_stock  out  STOCK_W  current nickel inventory
- done  out  1  one-cycle pulse: payout finished
- short  out  1  valid with done; unpaid amount >= 5
- remainder  out  N  valid with done; cents not paid

## Operation
- Internal registers: state, remaining[N-1:0], short_q, remainder_q.
- States: IDLE, DIME, NICKEL, DONE. All outputs are decoded from registered state and counters.
  - dime_req = (state==DIME)
  - nickel_req = (state==NICKEL)
  - req_ready = (state==IDLE)
  - done = (state==DONE)
- The same select function is used on accept and after every ack, applied to value r with registered stocks:
  - If r>=10 and dime_stock>0: go to DIME.
  - Else if r>=5 and nickel_stock>0: go to NICKEL.
  - Else: go to DONE.
- IDLE: on accept, remaining <= req_amount and next state = select(req_amount).
- DIME: on a coin_ack edge, remaining <= remaining-10 and dime_stock decrements. Next state = select(remaining-10) using the post-decrement stock. Without an ack, hold state.
- NICKEL: same as DIME, with 5 and nickel_stock.
- When entering DONE: remainder_q <= remaining (final value) and short_q <= (remaining>=5). The state then returns to IDLE after one cycle.
- Dimes are preferred. When dimes run out mid-payout, the balance continues in nickels. Amounts not a multiple of 5 leave the residue (amount mod 5) in remainder, with short=0 if it is below 5.
- Arithmetic is unsigned. Subtraction happens only when r >= coin value, so it never underflows.
- coin_ack is ignored in IDLE and DONE.
- Stock counters:
  - A restock adds 1, saturating at 2^STOCK_W-1.
  - An acked coin of that denomination subtracts 1.
  - Restock and ack on the same denomination in the same cycle leave the count unchanged.
  - Restock is accepted in any state.
- Reset, at any time including mid-payout:
  - state=IDLE, remaining=0.
  - dime_req, nickel_req, done, short = 0; remainder=0; req_ready=1 after reset release.
  - dime_stock=INIT_DIMES, nickel_stock=INIT_NICKELS.
  - Any partial payout is abandoned and not reported.

## Timing
- Request accepted at edge k: dime_req or nickel_req goes high in cycle k+1. For a zero or unpayable amount, done goes high in cycle k+1 instead.
- A coin request stays high until coin_ack. Each cycle with coin_ack high while a request is asserted counts exactly one coin. The request may stay high across consecutive coins; there is no mandatory gap cycle.
- Ack at edge j on the last coin: done is high in cycle j+1, and req_ready is high again in cycle j+2.
- The earliest back-to-back request acceptance is the edge that ends the first req_ready cycle.
- There is no timeout. A hopper that never acks holds the block in DIME or NICKEL until reset.

## Structure
- Shared package vend_pkg, also used by the vending controller:
  - state_t enum (IDLE, DIME, NICKEL, DONE)
  - DIME_VALUE=10, NICKEL_VALUE=5
- One sub-module, stock_counter #(STOCK_W, INIT), instanced twice. Ports: clk, reset, inc, dec, count. It implements saturating increment and simultaneous inc/dec cancelling.

## Test plan
- Amount 35, stocks 20/20, hopper acks immediately -> 3 dime acks then 1 nickel ack; done with short=0, remainder=0; stocks 17/19.
- Amount 35, dime_stock=1 -> 1 dime then 5 nickels; done with short=0, remainder=0; dime_stock=0.
- Amount 30, dime_stock=0, nickel_stock=2 -> 2 nickels; done with short=1, remainder=20.
- Amount 33 -> 3 dimes; done with short=0, remainder=3. Amount 0 -> done in cycle k+1 with no coin requests.
- Hopper delays ack by 4 cycles -> dime_req holds for 5 cycles and exactly one coin is counted. restock_dime on the same cycle as a dime ack -> dime_stock unchanged.
- Amount 40, reset asserted after the 2nd ack -> all outputs return to reset values immediately and stocks return to INIT values. A new request after reset completes normally.
